// File: rtl/bus_pkg.sv
// Shared definitions for the single-master handshake bus: state encoding,
// transfer direction codes and default widths.
package bus_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  localparam logic BUS_RD = 1'b1;
  localparam logic BUS_WR = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } bus_state_e;

endpackage

// File: rtl/bus_ram.sv
// Single-port word memory: synchronous write, registered read.
// Contents are deliberately left out of reset; only the read register clears.
module bus_ram #(
  parameter int AW    = 8,
  parameter int DW    = 8,
  parameter int DEPTH = 200
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [DEPTH];
  logic [DW-1:0] rdata_r;

  // write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  // registered read port
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r <= {DW{1'b0}};
    end else if (re) begin
      rdata_r <= mem_r[addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/bus_responder.sv
// Target side of the single-master handshake bus: grants the bus, accepts one
// strobed transfer at a time, waits WAIT cycles, commits to bus_ram and acks.
module bus_responder
  import bus_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = 200,
  parameter int WAIT  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mreq,
  output logic          mgrnt,
  input  logic          mas,
  input  logic          mrw,
  input  logic [AW-1:0] maddr,
  input  logic [DW-1:0] mwdata,
  output logic [DW-1:0] mrdata,
  output logic          mrdy,
  output logic          merr
);

  localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);
  localparam logic [3:0]  WAIT_LD   = 4'(WAIT);

  bus_state_e    state_r;
  bus_state_e    state_s;
  logic [3:0]    cnt_r;
  logic          rw_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wdata_r;
  logic          oor_r;
  logic          mgrnt_r;
  logic          mrdy_r;
  logic          merr_r;
  logic [DW-1:0] mrdata_r;

  logic          acc_rw_s;
  logic [AW-1:0] acc_addr_s;
  logic [DW-1:0] acc_wdata_s;
  logic          inrange_s;
  logic          commit_s;
  logic          ram_we_s;
  logic          ram_re_s;
  logic [DW-1:0] ram_rdata_s;

  // next-state decode; a strobe in GRANT wins over a simultaneous mreq drop
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (mreq) state_s = ST_GRANT;
        else      state_s = ST_IDLE;
      end
      ST_GRANT: begin
        if (mas) begin
          if (WAIT_LD == 4'd0) state_s = ST_ACK;
          else                 state_s = ST_WAIT;
        end else if (!mreq) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_GRANT;
        end
      end
      ST_WAIT: begin
        if (cnt_r <= 4'd1) state_s = ST_ACK;
        else               state_s = ST_WAIT;
      end
      ST_ACK: begin
        if (mreq) state_s = ST_GRANT;
        else      state_s = ST_IDLE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // with WAIT=0 the commit edge is the strobe edge itself, so bypass the latches
  always_comb begin
    if (state_r == ST_GRANT) begin
      acc_rw_s    = mrw;
      acc_addr_s  = maddr;
      acc_wdata_s = mwdata;
    end else begin
      acc_rw_s    = rw_r;
      acc_addr_s  = addr_r;
      acc_wdata_s = wdata_r;
    end
    inrange_s = ({1'b0, acc_addr_s} < DEPTH_LIM);
    commit_s  = (state_s == ST_ACK) && (state_r != ST_ACK) && !rst;
    ram_we_s  = commit_s && inrange_s && (acc_rw_s == BUS_WR);
    ram_re_s  = commit_s && inrange_s && (acc_rw_s == BUS_RD);
  end

  bus_ram #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we_s),
    .re    (ram_re_s),
    .addr  (acc_addr_s),
    .wdata (acc_wdata_s),
    .rdata (ram_rdata_s)
  );

  // state, wait counter and transfer latches
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      rw_r    <= BUS_WR;
      addr_r  <= {AW{1'b0}};
      wdata_r <= {DW{1'b0}};
      oor_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      if (state_r == ST_GRANT && mas) begin
        cnt_r   <= WAIT_LD;
        rw_r    <= mrw;
        addr_r  <= maddr;
        wdata_r <= mwdata;
      end else if (state_r == ST_WAIT && cnt_r != 4'd0) begin
        cnt_r <= cnt_r - 4'd1;
      end
      if (commit_s) begin
        oor_r <= !inrange_s;
      end
    end
  end

  // outputs are registered decodes of the current state, one cycle behind it
  always_ff @(posedge clk) begin
    if (rst) begin
      mgrnt_r  <= 1'b0;
      mrdy_r   <= 1'b0;
      merr_r   <= 1'b0;
      mrdata_r <= {DW{1'b0}};
    end else begin
      mgrnt_r <= (state_r != ST_IDLE);
      mrdy_r  <= (state_r == ST_ACK);
      merr_r  <= (state_r == ST_ACK) && oor_r;
      if (state_r == ST_ACK && rw_r == BUS_RD) begin
        mrdata_r <= oor_r ? {DW{1'b0}} : ram_rdata_s;
      end
    end
  end

  assign mgrnt  = mgrnt_r;
  assign mrdy   = mrdy_r;
  assign merr   = merr_r;
  assign mrdata = mrdata_r;

endmodule

// File: tb/tb_bus_responder.sv
// Directed self-checking bench for bus_responder at default parameters.
module tb_bus_responder;

  logic       clk;
  logic       rst;
  logic       mreq;
  logic       mgrnt;
  logic       mas;
  logic       mrw;
  logic [7:0] maddr;
  logic [7:0] mwdata;
  logic [7:0] mrdata;
  logic       mrdy;
  logic       merr;

  int checks = 0;
  int errors = 0;

  bus_responder dut (
    .clk    (clk),
    .rst    (rst),
    .mreq   (mreq),
    .mgrnt  (mgrnt),
    .mas    (mas),
    .mrw    (mrw),
    .maddr  (maddr),
    .mwdata (mwdata),
    .mrdata (mrdata),
    .mrdy   (mrdy),
    .merr   (merr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: plain, 1: keep mas asserted through WAIT/ACK, 2: drop mreq in WAIT
  task automatic xfer(input logic rw, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] exp_rd, input logic exp_err, input int mode,
                      input string tag);
    mas = 1'b1; mrw = rw; maddr = a; mwdata = d;
    tick();
    if (mode != 1) mas = 1'b0;
    if (mode == 2) mreq = 1'b0;
    chk({tag, "_w0"}, 32'(mrdy), 32'd0);
    tick();
    chk({tag, "_w1"}, 32'(mrdy), 32'd0);
    tick();
    chk({tag, "_w2"}, 32'(mrdy), 32'd0);
    tick();
    mas = 1'b0;
    chk({tag, "_rdy"}, 32'(mrdy), 32'd1);
    chk({tag, "_err"}, 32'(merr), 32'(exp_err));
    if (rw) chk({tag, "_data"}, 32'(mrdata), 32'(exp_rd));
  endtask

  task automatic regrant();
    mreq = 1'b1;
    tick();
    tick();
    chk("regrant", 32'(mgrnt), 32'd1);
  endtask

  initial begin
    logic [7:0] bb [4];
    bb[0] = 8'h81; bb[1] = 8'h92; bb[2] = 8'hA3; bb[3] = 8'hB4;
    rst = 1'b1; mreq = 1'b1; mas = 1'b0; mrw = 1'b0; maddr = 8'h00; mwdata = 8'h00;

    tick();
    tick();
    chk("rst_mgrnt", 32'(mgrnt), 32'd0);
    chk("rst_mrdy", 32'(mrdy), 32'd0);
    chk("rst_merr", 32'(merr), 32'd0);
    chk("rst_mrdata", 32'(mrdata), 32'd0);

    rst = 1'b0;
    tick();
    chk("grant_early", 32'(mgrnt), 32'd0);
    tick();
    chk("grant", 32'(mgrnt), 32'd1);
    mreq = 1'b0;
    tick();
    chk("release_early", 32'(mgrnt), 32'd1);
    tick();
    chk("release", 32'(mgrnt), 32'd0);

    regrant();
    xfer(1'b0, 8'h10, 8'hA5, 8'h00, 1'b0, 0, "wr10");
    xfer(1'b1, 8'h10, 8'h00, 8'hA5, 1'b0, 0, "rd10");
    xfer(1'b0, 8'h30, 8'h11, 8'h00, 1'b0, 0, "wr30");

    // strobe while not granted must be ignored
    mreq = 1'b0;
    tick();
    tick();
    chk("idle_mgrnt", 32'(mgrnt), 32'd0);
    mas = 1'b1; mrw = 1'b0; maddr = 8'h30; mwdata = 8'hEE;
    tick();
    mas = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("idle_mas_rdy", 32'(mrdy), 32'd0);
      chk("idle_mas_gnt", 32'(mgrnt), 32'd0);
    end
    regrant();
    xfer(1'b1, 8'h30, 8'h00, 8'h11, 1'b0, 0, "rd30");

    xfer(1'b0, 8'hC8, 8'h3C, 8'h00, 1'b1, 0, "wrC8");
    xfer(1'b1, 8'hC8, 8'h00, 8'h00, 1'b1, 0, "rdC8");
    xfer(1'b0, 8'hC7, 8'h5A, 8'h00, 1'b0, 0, "wrC7");
    xfer(1'b1, 8'hC7, 8'h00, 8'h5A, 1'b0, 0, "rdC7");

    for (int i = 0; i < 4; i++) xfer(1'b0, 8'h40 + 8'(i), bb[i], 8'h00, 1'b0, 0, "b2b_wr");
    for (int i = 0; i < 4; i++) xfer(1'b1, 8'h40 + 8'(i), 8'h00, bb[i], 1'b0, 0, "b2b_rd");

    xfer(1'b0, 8'h44, 8'hC5, 8'h00, 1'b0, 1, "wr44_noise");
    tick();
    chk("noise_rdy0", 32'(mrdy), 32'd0);
    tick();
    chk("noise_rdy1", 32'(mrdy), 32'd0);
    xfer(1'b1, 8'h44, 8'h00, 8'hC5, 1'b0, 0, "rd44");

    xfer(1'b0, 8'h50, 8'h66, 8'h00, 1'b0, 2, "wr50_drop");
    chk("drop_gnt_ack", 32'(mgrnt), 32'd1);
    tick();
    chk("drop_rdy_end", 32'(mrdy), 32'd0);
    chk("drop_gnt_end", 32'(mgrnt), 32'd0);
    regrant();
    xfer(1'b1, 8'h50, 8'h00, 8'h66, 1'b0, 0, "rd50");

    mreq = 1'b0;
    xfer(1'b0, 8'h60, 8'h3E, 8'h00, 1'b0, 0, "wr60_masdrop");
    tick();
    chk("masdrop_gnt", 32'(mgrnt), 32'd0);
    regrant();
    xfer(1'b1, 8'h60, 8'h00, 8'h3E, 1'b0, 0, "rd60");

    // reset asserted on the would-be commit edge of a write
    xfer(1'b0, 8'h20, 8'h19, 8'h00, 1'b0, 0, "wr20");
    mas = 1'b1; mrw = 1'b0; maddr = 8'h20; mwdata = 8'h77;
    tick();
    mas = 1'b0;
    tick();
    rst = 1'b1; mreq = 1'b0;
    tick();
    rst = 1'b0;
    chk("midrst_rdy", 32'(mrdy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_rdy_after", 32'(mrdy), 32'd0);
      chk("midrst_gnt_after", 32'(mgrnt), 32'd0);
    end
    regrant();
    xfer(1'b1, 8'h20, 8'h00, 8'h19, 1'b0, 0, "rd20");
    tick();
    chk("final_rdy", 32'(mrdy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
